// File: rtl/serial_bit_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder_if
//  Description : Load handshake and serial output bundle of serial_bit_feeder.
//                master = frame source / observer, slave = the feeder.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_bit_feeder_if #(
   parameter int WIDTH = 20,
   parameter int LEN_W = 5
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [LEN_W-1:0] load_len;
   logic             x;
   logic             bit_valid;
   logic             first_bit;
   logic             last_bit;
   logic             busy;

   modport master (
      output load_valid, load_data, load_len,
      input  load_ready, x, bit_valid, first_bit, last_bit, busy
   );

   modport slave (
      input  load_valid, load_data, load_len,
      output load_ready, x, bit_valid, first_bit, last_bit, busy
   );
endinterface
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_feeder
//  Description : Parallel-to-serial stimulus stage. Accepts a word plus a bit
//                count over valid/ready and emits one bit per clk on x with
//                first/last framing strobes. All outputs are registered.
//                Optional inter-frame gap: define SERIAL_BIT_FEEDER_GAP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_feeder #(
   parameter int WIDTH      = 20,
   parameter int LEN_W      = 5,
   parameter int LSB_FIRST  = 1,
   parameter int GAP_CYCLES = 2
) (
   input wire clk,
   input wire rst,
   serial_bit_feeder_if.slave bus
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_shift = 2'd1;
   localparam logic [1:0] c_gap   = 2'd2;

`ifdef SERIAL_BIT_FEEDER_GAP_EN
   localparam bit c_gap_on = (GAP_CYCLES > 0);
`else
   localparam bit c_gap_on = 1'b0;
`endif

   localparam int                 c_gap_w     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [c_gap_w-1:0] c_gap_load  = c_gap_w'(GAP_CYCLES);
   localparam logic [c_gap_w-1:0] c_gap_one   = c_gap_w'(1);
   localparam logic [LEN_W-1:0]   c_width_len = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0]   c_len_one   = LEN_W'(1);

   // State and datapath registers; r_cnt holds the bits left including the one on x
   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [LEN_W-1:0]   r_cnt;
   logic [c_gap_w-1:0] r_gap;

   // Registered outputs
   logic r_x, r_bit_valid, r_first, r_last, r_busy, r_load_ready;

   logic [1:0]         w_state_nxt;
   logic [WIDTH-1:0]   w_shreg_nxt;
   logic [LEN_W-1:0]   w_cnt_nxt;
   logic [c_gap_w-1:0] w_gap_nxt;
   logic               w_first_nxt;
   logic [WIDTH-1:0]   w_shreg_adv;
   logic               w_x_sel;
   logic               w_x_nxt, w_bit_valid_nxt, w_last_nxt, w_busy_nxt, w_ready_nxt;
   logic [LEN_W-1:0]   w_len_eff;
   logic               w_accept;
   logic               w_start;

   assign w_accept  = bus.load_valid && r_load_ready;
   assign w_len_eff = (bus.load_len > c_width_len) ? c_width_len : bus.load_len;
   // A zero-length load is accepted but never starts a frame
   assign w_start   = w_accept && (w_len_eff != '0);

   // Bit order only changes the shift direction and which end feeds x
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign w_shreg_adv = r_shreg >> 1;
         assign w_x_sel     = w_shreg_nxt[0];
      end else begin : g_msb_first
         assign w_shreg_adv = r_shreg << 1;
         assign w_x_sel     = w_shreg_nxt[WIDTH-1];
      end
   endgenerate

   // State register with datapath; reset abandons any frame immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   // Next-state: load on accept, shift while bits remain, then gap or idle
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_first_nxt = 1'b0;
      case (r_state)
         c_idle: begin
            if (w_start) begin
               w_state_nxt = c_shift;
               w_shreg_nxt = bus.load_data;
               w_cnt_nxt   = w_len_eff;
               w_first_nxt = 1'b1;
            end
         end
         c_shift: begin
            if (r_cnt != c_len_one) begin
               w_shreg_nxt = w_shreg_adv;
               w_cnt_nxt   = r_cnt - c_len_one;
            end else if (c_gap_on) begin
               w_state_nxt = c_gap;
               w_gap_nxt   = c_gap_load;
               w_shreg_nxt = '0;
               w_cnt_nxt   = '0;
            end else if (w_start) begin
               // Back-to-back: next frame's first bit follows without a bubble
               w_shreg_nxt = bus.load_data;
               w_cnt_nxt   = w_len_eff;
               w_first_nxt = 1'b1;
            end else begin
               w_state_nxt = c_idle;
               w_shreg_nxt = '0;
               w_cnt_nxt   = '0;
            end
         end
         c_gap: begin
            if (r_gap != c_gap_one) begin
               w_gap_nxt = r_gap - c_gap_one;
            end else if (w_start) begin
               w_state_nxt = c_shift;
               w_gap_nxt   = '0;
               w_shreg_nxt = bus.load_data;
               w_cnt_nxt   = w_len_eff;
               w_first_nxt = 1'b1;
            end else begin
               w_state_nxt = c_idle;
               w_gap_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = c_idle;
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_gap_nxt   = '0;
         end
      endcase
   end

   // Output decode of the upcoming state, registered below so outputs are flops
   always_comb begin
      w_x_nxt         = 1'b0;
      w_bit_valid_nxt = 1'b0;
      w_last_nxt      = 1'b0;
      w_busy_nxt      = 1'b0;
      w_ready_nxt     = 1'b1;
      case (w_state_nxt)
         c_shift: begin
            w_x_nxt         = w_x_sel;
            w_bit_valid_nxt = 1'b1;
            w_last_nxt      = (w_cnt_nxt == c_len_one);
            w_busy_nxt      = 1'b1;
            w_ready_nxt     = (w_cnt_nxt == c_len_one) && !c_gap_on;
         end
         c_gap: begin
            w_busy_nxt  = 1'b1;
            w_ready_nxt = (w_gap_nxt == c_gap_one);
         end
         default: begin
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x          <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_first      <= 1'b0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
         r_load_ready <= 1'b1;
      end else begin
         r_x          <= w_x_nxt;
         r_bit_valid  <= w_bit_valid_nxt;
         r_first      <= w_first_nxt;
         r_last       <= w_last_nxt;
         r_busy       <= w_busy_nxt;
         r_load_ready <= w_ready_nxt;
      end
   end

   assign bus.x          = r_x;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.first_bit  = r_first;
   assign bus.last_bit   = r_last;
   assign bus.busy       = r_busy;
   assign bus.load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_feeder
//  Description : Self-checking bench for serial_bit_feeder. An LSB-first and an
//                MSB-first instance share one stimulus; a queue-based model of
//                the emitted stream predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_bit_feeder;

`ifdef SERIAL_BIT_FEEDER_GAP_EN
   localparam int c_gap = 2;
`else
   localparam int c_gap = 0;
`endif
   localparam logic [11:0] c_rst_obs = 12'b000001_000001;

   typedef struct packed {
      logic bv;
      logic x;
      logic first;
      logic last;
   } ent_t;

   logic        clk;
   logic        rst;
   logic        drv_valid;
   logic [19:0] drv_data;
   logic [4:0]  drv_len;

   ent_t  ql[$];
   ent_t  qm[$];
   logic  exp_ready;
   logic  last_accept;
   logic  [11:0] expv;
   logic  [11:0] obs;
   int    checks = 0;
   int    passes = 0;

   serial_bit_feeder_if #(.WIDTH(20), .LEN_W(5)) ifl ();
   serial_bit_feeder_if #(.WIDTH(20), .LEN_W(5)) ifm ();

   assign ifl.load_valid = drv_valid;
   assign ifl.load_data  = drv_data;
   assign ifl.load_len   = drv_len;
   assign ifm.load_valid = drv_valid;
   assign ifm.load_data  = drv_data;
   assign ifm.load_len   = drv_len;

   assign obs = {ifl.x, ifl.bit_valid, ifl.first_bit, ifl.last_bit, ifl.busy, ifl.load_ready,
                 ifm.x, ifm.bit_valid, ifm.first_bit, ifm.last_bit, ifm.busy, ifm.load_ready};

   serial_bit_feeder #(.WIDTH(20), .LEN_W(5), .LSB_FIRST(1), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .bus(ifl));
   serial_bit_feeder #(.WIDTH(20), .LEN_W(5), .LSB_FIRST(0), .GAP_CYCLES(2)) dut_msb (
      .clk(clk), .rst(rst), .bus(ifm));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: an accepted frame appends its bits (and any gap slots) to a queue;
   // one entry is consumed per cycle, and ready holds while the queue is empty.
   function automatic void push_frame(input logic [19:0] d, input logic [4:0] n);
      int   l;
      ent_t e;
      l = (n > 5'd20) ? 20 : int'(n);
      for (int k = 0; k < l; k++) begin
         e.bv = 1'b1; e.first = (k == 0); e.last = (k == l - 1);
         e.x = d[k];      ql.push_back(e);
         e.x = d[19 - k]; qm.push_back(e);
      end
      if (l > 0) begin
         for (int g = 0; g < c_gap; g++) begin
            ql.push_back(ent_t'(0));
            qm.push_back(ent_t'(0));
         end
      end
   endfunction

   task automatic reset_model();
      ql.delete();
      qm.delete();
      exp_ready = 1'b1;
   endtask

   task automatic step();
      ent_t el, em;
      logic bz;
      last_accept = drv_valid && exp_ready;
      @(posedge clk);
      if (last_accept) push_frame(drv_data, drv_len);
      bz = (ql.size() != 0);
      el = '0;
      em = '0;
      if (bz) begin
         el = ql.pop_front();
         em = qm.pop_front();
      end
      exp_ready = (ql.size() == 0);
      expv = {el.x, el.bv, el.first, el.last, bz, exp_ready,
              em.x, em.bv, em.first, em.last, bz, exp_ready};
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== c_rst_obs) $display("FAIL reset_state: got %b want %b", obs, c_rst_obs);
      else passes++;
      #1 rst = 1'b0;
      reset_model();
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (obs !== expv) $display("FAIL reset_idle c%0d: got %b want %b", c, obs, expv);
         else passes++;
      end
   endtask

   task automatic test_directed20();
      logic [19:0] got;
      logic [19:0] want;
      int nb;
      got = '0; nb = 0;
      want = 20'b11110000000111000100;
      drv_data = want; drv_len = 5'd20; drv_valid = 1'b1;
      for (int c = 0; c < 22 + c_gap; c++) begin
         step();
         if (last_accept) drv_valid = 1'b0;
         checks++;
         if (obs !== expv) $display("FAIL directed20 c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (ifl.bit_valid === 1'b1 && nb < 20) begin got[nb] = ifl.x; nb++; end
      end
      checks++;
      if (got !== want || nb != 20) $display("FAIL directed20_bits: got %b n=%0d want %b n=20", got, nb, want);
      else passes++;
      checks++;
      if ({ifl.load_ready, ifl.busy} !== 2'b10) $display("FAIL directed20_idle: got rdy/busy %b want 10", {ifl.load_ready, ifl.busy});
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [4:0] sx, sf, sl;
      int n, phase, bubble;
      logic a_acc, b_pend;
      sx = '0; sf = '0; sl = '0; n = 0; phase = 0; bubble = 0; a_acc = 0; b_pend = 0;
      drv_data = 20'b101; drv_len = 5'd3; drv_valid = 1'b1;
      for (int c = 0; c < 10 + c_gap; c++) begin
         step();
         if (last_accept && !a_acc) begin a_acc = 1'b1; drv_valid = 1'b0; end
         else if (last_accept && b_pend) begin b_pend = 1'b0; drv_valid = 1'b0; end
         checks++;
         if (obs !== expv) $display("FAIL back_to_back c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (ifl.bit_valid === 1'b1 && n < 5) begin
            sx[4 - n] = ifl.x; sf[4 - n] = ifl.first_bit; sl[4 - n] = ifl.last_bit; n++;
         end
         if (phase == 1) begin
            if (ifl.bit_valid === 1'b1) phase = 2;
            else bubble++;
         end
         if (phase == 0 && ifl.last_bit === 1'b1) begin
            phase = 1;
            drv_data = 20'b11; drv_len = 5'd2; drv_valid = 1'b1; b_pend = 1'b1;
         end
      end
      checks++;
      if ({sx, sf, sl} !== {5'b10111, 5'b10010, 5'b00101})
         $display("FAIL back_to_back_stream: got x=%b f=%b l=%b want x=10111 f=10010 l=00101", sx, sf, sl);
      else passes++;
      checks++;
      if (bubble != c_gap) $display("FAIL back_to_back_bubble: got %0d want %0d", bubble, c_gap);
      else passes++;
   endtask

   task automatic test_boundary();
      int nb;
      // zero length: accepted, nothing emitted
      drv_data = 20'hFFFFF; drv_len = 5'd0; drv_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         if (last_accept) drv_valid = 1'b0;
         checks++;
         if (obs !== expv || ifl.bit_valid !== 1'b0) $display("FAIL len0 c%0d: got %b want %b", c, obs, expv);
         else passes++;
      end
      // single bit: first and last together
      drv_data = 20'($urandom) | 20'h1; drv_len = 5'd1; drv_valid = 1'b1;
      step();
      drv_valid = 1'b0;
      checks++;
      if ({ifl.x, ifl.bit_valid, ifl.first_bit, ifl.last_bit} !== 4'b1111)
         $display("FAIL len1: got %b want 1111", {ifl.x, ifl.bit_valid, ifl.first_bit, ifl.last_bit});
      else passes++;
      for (int c = 0; c < 2 + c_gap; c++) begin
         step();
         checks++;
         if (obs !== expv) $display("FAIL len1_after c%0d: got %b want %b", c, obs, expv);
         else passes++;
      end
      // overlong: clamped to WIDTH
      nb = 0;
      drv_data = 20'($urandom); drv_len = 5'd31; drv_valid = 1'b1;
      for (int c = 0; c < 24 + c_gap; c++) begin
         step();
         if (last_accept) drv_valid = 1'b0;
         checks++;
         if (obs !== expv) $display("FAIL len31 c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (ifl.bit_valid === 1'b1) nb++;
      end
      checks++;
      if (nb != 20) $display("FAIL len31_count: got %0d want 20", nb);
      else passes++;
   endtask

   task automatic test_msb_first();
      logic [3:0] sx;
      int n;
      sx = '0; n = 0;
      drv_data = 20'hF0000; drv_len = 5'd4; drv_valid = 1'b1;
      for (int c = 0; c < 7 + c_gap; c++) begin
         step();
         if (last_accept) drv_valid = 1'b0;
         checks++;
         if (obs !== expv) $display("FAIL msb_first c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (ifm.bit_valid === 1'b1) begin
            if (n < 4) sx[3 - n] = ifm.x;
            n++;
         end
      end
      checks++;
      if (sx !== 4'b1111 || n != 4) $display("FAIL msb_first_bits: got %b n=%0d want 1111 n=4", sx, n);
      else passes++;
   endtask

   task automatic test_async_reset();
      int nb;
      drv_data = 20'($urandom) | 20'hFFF00; drv_len = 5'd20; drv_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (last_accept) drv_valid = 1'b0;
         checks++;
         if (obs !== expv) $display("FAIL async_rst_pre c%0d: got %b want %b", c, obs, expv);
         else passes++;
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (obs !== c_rst_obs) $display("FAIL async_rst_immediate: got %b want %b", obs, c_rst_obs);
      else passes++;
      #1 rst = 1'b0;
      reset_model();
      nb = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         checks++;
         if (obs !== expv) $display("FAIL async_rst_post c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (ifl.bit_valid === 1'b1 || ifl.last_bit === 1'b1 || ifm.bit_valid === 1'b1) nb++;
      end
      checks++;
      if (nb != 0) $display("FAIL async_rst_residue: got %0d bit cycles want 0", nb);
      else passes++;
   endtask

   task automatic test_gap();
      int phase, gaps;
      logic f1, f2;
      phase = 0; gaps = 0; f1 = 0; f2 = 0;
      drv_data = 20'b10; drv_len = 5'd2; drv_valid = 1'b1;
      for (int c = 0; c < 10 + c_gap; c++) begin
         step();
         if (last_accept && !f1) begin f1 = 1'b1; drv_data = 20'b01; end
         else if (last_accept && !f2) begin f2 = 1'b1; drv_valid = 1'b0; end
         checks++;
         if (obs !== expv) $display("FAIL gap c%0d: got %b want %b", c, obs, expv);
         else passes++;
         if (phase == 1) begin
            if (ifl.bit_valid === 1'b1) phase = 2;
            else begin
               gaps++;
               checks++;
               if (ifl.load_ready !== (gaps == c_gap))
                  $display("FAIL gap_ready g%0d: got %b want %b", gaps, ifl.load_ready, (gaps == c_gap));
               else passes++;
            end
         end
         if (phase == 0 && ifl.last_bit === 1'b1) phase = 1;
      end
      checks++;
      if (gaps != c_gap || !f2) $display("FAIL gap_count: got %0d want %0d", gaps, c_gap);
      else passes++;
   endtask

   task automatic test_random();
      int idle, bound;
      for (int f = 0; f < 30; f++) begin
         idle = $urandom_range(0, 2);
         drv_valid = 1'b0;
         for (int i = 0; i < idle; i++) begin
            drv_data = 20'($urandom); drv_len = 5'($urandom);
            step();
            checks++;
            if (obs !== expv) $display("FAIL random_idle f%0d: got %b want %b", f, obs, expv);
            else passes++;
         end
         drv_data = 20'($urandom);
         drv_len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
         drv_valid = 1'b1;
         bound = 0;
         do begin
            step();
            bound++;
            checks++;
            if (obs !== expv) $display("FAIL random f%0d: got %b want %b", f, obs, expv);
            else passes++;
         end while (!last_accept && bound < 40);
         checks++;
         if (!last_accept) $display("FAIL random_accept_timeout f%0d: got no accept want accept", f);
         else passes++;
         drv_valid = 1'b0; drv_data = 20'($urandom); drv_len = 5'($urandom);
      end
      for (int c = 0; c < 24 + c_gap; c++) begin
         step();
         checks++;
         if (obs !== expv) $display("FAIL random_drain c%0d: got %b want %b", c, obs, expv);
         else passes++;
      end
   endtask

   initial begin
      rst = 1'b1;
      drv_valid = 1'b0; drv_data = '0; drv_len = '0;
      exp_ready = 1'b1; last_accept = 1'b0; expv = '0;
      test_reset();
      test_directed20();
      test_back_to_back();
      test_boundary();
      test_msb_first();
      test_async_reset();
      test_gap();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial stimulus stage that sits directly upstream of the sequence recognizer (JK/D flip-flop machines) and drives its serial input x.
- Accepts a word plus a bit count over a valid/ready handshake, then emits one bit per clk with framing strobes.
- Replaces ad-hoc shift-by-delay stimulus, so x changes only on a clock edge and the recognizer sees clean, cycle-aligned data.

Parameters:
- WIDTH, 20, maximum frame length in bits; also the load_data width.
- LEN_W, 5, width of load_len; must satisfy 2^LEN_W > WIDTH.
- LSB_FIRST, 1, 1 = emit bit 0 first; 0 = emit bit WIDTH-1 first (MSB-aligned).
- GAP_CYCLES, 2, idle cycles between frames; used only when GAP_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-high.
- load_valid  in  1  a frame is offered.
- load_ready  out  1  the feeder can accept a frame this cycle.
- load_data  in  WIDTH  frame bits.
- load_len  in  LEN_W  number of bits to emit.
- x  out  1  serial bit to the recognizer.
- bit_valid  out  1  x carries a frame bit this cycle.
- first_bit  out  1  high with the first bit of a frame.
- last_bit  out  1  high with the final bit of a frame.
- busy  out  1  the state is not IDLE.

Behaviour:
- Reset: state IDLE; shift register and counter cleared; x=0, bit_valid=0, first_bit=0, last_bit=0, busy=0, load_ready=1. Reset is asserted asynchronously and takes effect immediately.
- Reset mid-frame: the frame is abandoned with no last_bit pulse, and no remaining bits are emitted after rst falls.
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being emitted.
  - GAP: inter-frame idle cycles; this state exists only with GAP_EN.
- Accept condition: load_valid && load_ready at a rising edge.
- load_ready is 1 in IDLE. It is also 1 in SHIFT during the last-bit cycle, which allows back-to-back frames. It is 0 otherwise.
- Effective length L = min(load_len, WIDTH). If L=0, the load is accepted and dropped: no bits, no strobes, state unchanged.
- Latency: for a load accepted at edge N, the first bit appears on x after edge N, with bit_valid=1 and first_bit=1. Bit k is presented after edge N+k. All outputs are registered.
- Bit order:
  - LSB_FIRST=1: bit 0, then bit 1, up to bit L-1.
  - LSB_FIRST=0: bit WIDTH-1 downward through bit WIDTH-L.
- last_bit=1 together with bit L-1. If L=1, first_bit and last_bit are both 1 in the same cycle.
- Transitions:
  - IDLE to SHIFT on a load with L>0.
  - SHIFT to SHIFT on a new accept during the last bit. The new first bit follows the old last bit on the very next cycle, with no bubble.
  - SHIFT to IDLE after the last bit when no new load is accepted.
- Outside SHIFT: x=0, bit_valid=0, first_bit=0, last_bit=0.
- load_data and load_len are sampled only at the accept edge. Later changes have no effect on the frame in flight.
- load_valid while load_ready=0 is ignored; the source must hold it.
- busy=1 in SHIFT and GAP.

Optional Feature:
- Macro: SERIAL_BIT_FEEDER_GAP_EN.
- Defined:
  - After the last bit, the feeder enters GAP for exactly GAP_CYCLES cycles. In GAP, x=0 and bit_valid=0.
  - load_ready=0 during the last bit and all gap cycles except the final one; it is 1 in the final gap cycle.
  - An accept in the final gap cycle starts the next frame on the following cycle. Otherwise the feeder goes to IDLE.
  - GAP_CYCLES=0 behaves as if the macro were not defined.
- Not defined: no GAP state; back-to-back behaviour is exactly as described in Behaviour.

Test Plan:
- Reset release, then load 20'b11110000000111000100 with len 20 and LSB_FIRST=1. Required: x over 20 cycles = 0,0,1,0,0,0,1,1,1,0,0,0,0,0,0,0,1,1,1,1. first_bit in cycle 1 only, last_bit in cycle 20 only, then IDLE with load_ready=1.
- Back-to-back: frame A = 3'b101 (len 3), with frame B = 2'b11 (len 2) offered during A's last bit. Required: x = 1,0,1,1,1 contiguous, bit_valid held high for 5 cycles, first_bit in cycles 1 and 4, last_bit in cycles 3 and 5.
- Boundary lengths:
  - len=0: accepted, bit_valid stays 0.
  - len=1 with data bit0=1: one cycle of x=1 with first_bit=last_bit=1.
  - len=31: clamped to 20 bits.
- Async rst pulse of 2 ns asserted mid-frame, after the 8th bit. Required: all outputs go to 0 immediately, load_ready=1, no further bits or last_bit.
- LSB_FIRST=0, WIDTH=20, load 20'hF0000 with len 4. Required: x = 1,1,1,1.
- With SERIAL_BIT_FEEDER_GAP_EN and GAP_CYCLES=2, two 2-bit frames with load_valid held high. Required: exactly 2 idle cycles between frames, and load_ready high only in the second gap cycle.
